// File: rtl/spi_slave_byte_if.sv
// SPI pin and byte-FIFO signal bundle for spi_slave_byte.
// The slave modport is the responder's view; master is the view of whatever drives it.
interface spi_slave_byte_if #(
  parameter int unsigned BYTE_CNT_W = 8
);
  logic                  sclk;
  logic                  n_cs;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [7:0]            tx_data;
  logic                  tx_empty;
  logic                  tx_rdreq;
  logic [7:0]            rx_data;
  logic                  rx_wrreq;
  logic                  frame_done;
  logic [BYTE_CNT_W-1:0] frame_bytes;
  logic                  abort;

  modport slave (
    input  sclk, n_cs, mosi, tx_data, tx_empty,
    output miso, miso_oe, tx_rdreq, rx_data, rx_wrreq, frame_done, frame_bytes, abort
  );

  modport master (
    output sclk, n_cs, mosi, tx_data, tx_empty,
    input  miso, miso_oe, tx_rdreq, rx_data, rx_wrreq, frame_done, frame_bytes, abort
  );
endinterface

// File: rtl/spi_slave_byte.sv
// Byte-oriented SPI responder: oversamples sclk/n_cs/mosi on clk, shifts TX FIFO bytes out
// on miso and pushes each complete received byte to the RX FIFO.
module spi_slave_byte #(
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF,
  parameter int unsigned BYTE_CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  spi_slave_byte_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                state_q;
  logic [2:0]            sclk_s;
  logic [2:0]            ncs_s;
  logic [1:0]            mosi_s;
  logic [7:0]            tx_sr_q;
  logic [7:0]            rx_sr_q;
  logic [2:0]            bit_cnt_q;
  logic [BYTE_CNT_W-1:0] byte_cnt_q;
  logic                  miso_q;
  logic                  miso_oe_q;
  logic                  tx_rdreq_q;
  logic [7:0]            rx_data_q;
  logic                  rx_wrreq_q;
  logic                  frame_done_q;
  logic [BYTE_CNT_W-1:0] frame_bytes_q;
  logic                  abort_q;

  logic                  lead_evt, trail_evt, sample_evt, shift_evt;
  logic                  ncs_fall, ncs_high, byte_done, reload;
  logic [2:0]            bit_cnt_nxt;
  logic [BYTE_CNT_W-1:0] byte_cnt_nxt;
  logic [7:0]            rx_byte, load_byte;

  // Stages [1:0] synchronize; stage [2] is the previous synced value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= {3{CPOL}};
      ncs_s  <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], bus.sclk};
      ncs_s  <= {ncs_s[1:0], bus.n_cs};
      mosi_s <= {mosi_s[0], bus.mosi};
    end
  end

  always_comb begin
    lead_evt     = CPOL ? (~sclk_s[1] & sclk_s[2]) : (sclk_s[1] & ~sclk_s[2]);
    trail_evt    = CPOL ? (sclk_s[1] & ~sclk_s[2]) : (~sclk_s[1] & sclk_s[2]);
    // Edges only count inside a frame; an edge coincident with the n_cs rise still counts.
    sample_evt   = (state_q == StActive) & (CPHA ? trail_evt : lead_evt);
    shift_evt    = (state_q == StActive) & (CPHA ? lead_evt : trail_evt);
    ncs_fall     = ~ncs_s[1] & ncs_s[2];
    ncs_high     = ncs_s[1];
    byte_done    = sample_evt & (bit_cnt_q == 3'd7);
    bit_cnt_nxt  = sample_evt ? bit_cnt_q + 3'd1 : bit_cnt_q;
    byte_cnt_nxt = (byte_done && (byte_cnt_q != '1)) ? byte_cnt_q + BYTE_CNT_W'(1) : byte_cnt_q;
    rx_byte      = {rx_sr_q[6:0], mosi_s[1]};
    load_byte    = bus.tx_empty ? FILL_BYTE : bus.tx_data;
    // CPHA=0 reloads on the trailing edge after the 8th sample, CPHA=1 on the 8th sample.
    reload       = (CPHA ? byte_done : (shift_evt & (bit_cnt_q == 3'd0))) & ~ncs_high;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      tx_sr_q       <= 8'h00;
      rx_sr_q       <= 8'h00;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= '0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      tx_rdreq_q    <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_wrreq_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_bytes_q <= '0;
      abort_q       <= 1'b0;
    end else begin
      tx_rdreq_q   <= 1'b0;
      rx_wrreq_q   <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ncs_fall) begin
            state_q    <= StActive;
            tx_sr_q    <= load_byte;
            tx_rdreq_q <= ~bus.tx_empty;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            miso_oe_q  <= 1'b1;
          end
        end
        StActive: begin
          if (sample_evt) begin
            rx_sr_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_nxt;
          end
          if (byte_done) begin
            rx_data_q  <= rx_byte;
            rx_wrreq_q <= 1'b1;
            byte_cnt_q <= byte_cnt_nxt;
          end
          if (reload) begin
            tx_sr_q    <= load_byte;
            tx_rdreq_q <= ~bus.tx_empty;
          end else if (shift_evt) begin
            tx_sr_q <= {tx_sr_q[6:0], 1'b0};
          end
          if (CPHA && shift_evt) begin
            miso_q <= tx_sr_q[7];
          end
          // A partially received byte is dropped; abort flags it.
          if (ncs_high) begin
            state_q       <= StIdle;
            miso_oe_q     <= 1'b0;
            frame_done_q  <= 1'b1;
            frame_bytes_q <= byte_cnt_nxt;
            abort_q       <= (bit_cnt_nxt != 3'd0);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.miso        = CPHA ? miso_q : tx_sr_q[7];
  assign bus.miso_oe     = miso_oe_q;
  assign bus.tx_rdreq    = tx_rdreq_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_wrreq    = rx_wrreq_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_bytes = frame_bytes_q;
  assign bus.abort       = abort_q;

endmodule
